// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the RV32I datapath: sequences fetch/decode/execute/memory/writeback
// for lw, sw, R-type and beq, traps anything else, and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BEQ      = 4'd8;
  localparam logic [3:0] TRAP     = 4'd9;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             trap_reg;
  logic             retire;
  logic             req_raw, write_raw, irw_raw, pc_write, branch, regw_raw;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXECR:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  // Only the final state of each instruction class can lead back to FETCH as a retirement.
  assign retire = (state_next == FETCH) &&
                  (state_reg == MEMWB || state_reg == MEMWRITE ||
                   state_reg == ALUWB || state_reg == BEQ);

  always_comb begin
    req_raw    = 1'b0;
    write_raw  = 1'b0;
    irw_raw    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    regw_raw   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    case (state_reg)
      FETCH: begin
        req_raw    = 1'b1;
        irw_raw    = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        regw_raw   = 1'b1;
      end
      MEMWRITE: begin
        req_raw   = 1'b1;
        write_raw = 1'b1;
        adr_src   = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      ALUWB: regw_raw = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Side-effecting strobes are held off for as long as reset is asserted.
  assign mem_req   = rst_n & req_raw;
  assign mem_write = rst_n & write_raw;
  assign ir_write  = rst_n & irw_raw;
  assign pc_en     = rst_n & (pc_write | (branch & zero));
  assign reg_write = rst_n & regw_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      retired_reg <= '0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire) retired_reg <= retired_reg + 1'b1;
      if (state_next == TRAP) trap_reg <= 1'b1;
    end
  end

  assign state_dbg     = state_reg;
  assign retired       = retired_reg;
  assign illegal_instr = trap_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into an expected
// per-cycle trace (state, drive, outputs) built from the instruction class and wait counts.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_en, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] state_dbg;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  typedef struct {
    int         st;
    logic       mr;
    logic [6:0] op;
    logic [13:0] ov;
  } step_t;
  step_t trace[$];

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_en(pc_en), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .illegal_instr(illegal_instr),
    .state_dbg(state_dbg), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {mem_req, mem_write, adr_src, ir_write, pc_en, reg_write,
            alu_src_a, alu_src_b, result_src, alu_op};
  endfunction

  function automatic void add(input int st, input logic mr, input logic [6:0] op,
                              input logic [13:0] ov);
    step_t s;
    s.st = st; s.mr = mr; s.op = op; s.ov = ov;
    trace.push_back(s);
  endfunction

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic do_step(input step_t s, input logic z, input logic ill);
    opcode = s.op; mem_ready = s.mr; zero = z;
    @(negedge clk);
    check_eq("state", 32'(state_dbg), 32'(s.st));
    check_eq("outs", 32'(dut_vec()), 32'(s.ov));
    check_eq("illegal", 32'(illegal_instr), 32'(ill));
    check_eq("retired_hold", 32'(retired), 32'(cnt_model));
    @(posedge clk); #1;
  endtask

  function automatic void add_fetch(input int fw);
    for (int i = 0; i < fw; i++)
      add(0, 1'b0, 7'($urandom), {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00});
    add(0, 1'b1, 7'($urandom), {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00});
  endfunction

  function automatic void build(input int kind, input int fw, input int mw, input logic z);
    logic [6:0] op;
    op = (kind == 0) ? OP_R : (kind == 1) ? OP_LW : (kind == 2) ? OP_SW : OP_BEQ;
    trace.delete();
    add_fetch(fw);
    add(1, 1'($urandom), op, {6'b0, 2'b01, 2'b01, 2'b00, 2'b00});
    case (kind)
      0: begin
        add(6, 1'($urandom), op, {6'b0, 2'b10, 2'b00, 2'b00, 2'b10});
        add(7, 1'($urandom), op, {6'b000001, 8'b0});
      end
      1: begin
        add(2, 1'($urandom), op, {6'b0, 2'b10, 2'b01, 2'b00, 2'b00});
        for (int i = 0; i < mw; i++) add(3, 1'b0, op, {6'b101000, 8'b0});
        add(3, 1'b1, op, {6'b101000, 8'b0});
        add(4, 1'($urandom), op, {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00});
      end
      2: begin
        add(2, 1'($urandom), op, {6'b0, 2'b10, 2'b01, 2'b00, 2'b00});
        for (int i = 0; i < mw; i++) add(5, 1'b0, op, {6'b111000, 8'b0});
        add(5, 1'b1, op, {6'b111000, 8'b0});
      end
      default: add(8, 1'($urandom), op, {4'b0000, z, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01});
    endcase
  endfunction

  task automatic run_instr(input int kind, input int fw, input int mw, input logic z);
    build(kind, fw, mw, z);
    foreach (trace[i]) do_step(trace[i], z, 1'b0);
    cnt_model = (cnt_model + 1) % 16;
    check_eq("retired", 32'(retired), 32'(cnt_model));
    $display("instr kind=%0d fw=%0d mw=%0d zero=%0d cycles=%0d retired=%0d",
             kind, fw, mw, z, trace.size(), retired);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    @(negedge clk);
    check_eq("rst_forced", 32'({mem_req, mem_write, ir_write, pc_en, reg_write}), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_illegal", 32'(illegal_instr), 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    cnt_model = 0;
    $display("reset applied");
  endtask

  initial begin
    step_t s;
    do_reset();

    // Directed cases from the test plan
    run_instr(0, 0, 0, 1'b0);
    run_instr(1, 0, 2, 1'b0);
    run_instr(2, 0, 0, 1'b1);
    run_instr(3, 0, 0, 1'b1);
    run_instr(3, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom));

    // Illegal opcode traps and stays trapped
    trace.delete();
    add_fetch(0);
    add(1, 1'b1, 7'h7F, {6'b0, 2'b01, 2'b01, 2'b00, 2'b00});
    foreach (trace[i]) do_step(trace[i], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s.st = 9; s.mr = 1'($urandom); s.op = 7'($urandom); s.ov = 14'd0;
      do_step(s, 1'($urandom), 1'b1);
    end
    $display("trap held for 10 cycles");
    do_reset();

    // Counter wrap at 2^4
    for (int n = 0; n < 15; n++)
      run_instr(int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 1)), 1'($urandom));
    check_eq("pre_wrap", 32'(retired), 32'd15);
    run_instr(0, 0, 0, 1'b0);
    check_eq("wrap", 32'(retired), 32'd0);

    // Reset while a store waits in MEMWRITE
    build(2, 0, 3, 1'b0);
    for (int i = 0; i < 3; i++) do_step(trace[i], 1'b0, 1'b0);
    rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_SW;
    @(negedge clk);
    check_eq("rstw_state", 32'(state_dbg), 32'd5);
    check_eq("rstw_write", 32'({mem_req, mem_write}), 32'd0);
    @(posedge clk); #1;
    check_eq("rstw_fetch", 32'(state_dbg), 32'd0);
    check_eq("rstw_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    cnt_model = 0;
    $display("reset during memwrite");
    run_instr(0, 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
